// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Load-use stall and taken branch/jump wrong-path flush control
//               for the IF/ID and ID/EX stage registers. Also keeps saturating
//               stall and redirect event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int BR_PENALTY = 2,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             Clr,
    input  logic [4:0]       D_Rs,
    input  logic [4:0]       D_Rt,
    input  logic             D_UsesRt,
    input  logic [4:0]       E_Rt,
    input  logic             E_MemtoReg,
    input  logic             E_RegWr,
    input  logic             E_Branch,
    input  logic             E_Zero,
    input  logic             E_Jump,
    output logic             PC_Wr,
    output logic             PC_Sel,
    output logic             IF_ID_Wr,
    output logic             IF_ID_Clrn,
    output logic             ID_EX_Clrn,
    output logic             Busy,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
);

    localparam logic [3:0]       c_rem_init = 4'(BR_PENALTY - 1);
    localparam logic             c_multi    = (BR_PENALTY > 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_rem;
    logic [3:0] w_rem_nxt;
    logic       w_redirect;
    logic       w_loaduse;
    logic       w_stall_inc;
    logic       w_flush_inc;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    assign w_redirect = (E_Branch & E_Zero) | E_Jump;
    assign w_loaduse  = E_MemtoReg & E_RegWr & (E_Rt != 5'd0) &
                        ((E_Rt == D_Rs) | (D_UsesRt & (E_Rt == D_Rt)));

    always_comb begin
        PC_Wr       = 1'b1;
        PC_Sel      = 1'b0;
        IF_ID_Wr    = 1'b1;
        IF_ID_Clrn  = 1'b1;
        ID_EX_Clrn  = 1'b1;
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_stall_inc = 1'b0;
        w_flush_inc = 1'b0;
        if (Clr) begin
            PC_Wr       = 1'b0;
            IF_ID_Wr    = 1'b0;
            IF_ID_Clrn  = 1'b0;
            ID_EX_Clrn  = 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // Redirect wins: the ID instruction is squashed, so a
                    // coincident load-use hazard is irrelevant.
                    if (w_redirect) begin
                        PC_Sel      = 1'b1;
                        IF_ID_Clrn  = 1'b0;
                        ID_EX_Clrn  = 1'b0;
                        w_flush_inc = 1'b1;
                        if (c_multi) begin
                            w_state_nxt = ST_FLUSH;
                            w_rem_nxt   = c_rem_init;
                        end
                    end else if (w_loaduse) begin
                        PC_Wr       = 1'b0;
                        IF_ID_Wr    = 1'b0;
                        ID_EX_Clrn  = 1'b0;
                        w_stall_inc = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    IF_ID_Clrn = 1'b0;
                    ID_EX_Clrn = 1'b0;
                    w_rem_nxt  = r_rem - 4'd1;
                    if (r_rem == 4'd1) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Clr) begin
            r_state     <= ST_RUN;
            r_rem       <= 4'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            if (w_stall_inc && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_inc && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign Busy      = (r_state == ST_FLUSH);
    assign Stall_Cnt = r_stall_cnt;
    assign Flush_Cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench for hazard_ctrl; two instances with different
//               penalty/counter widths share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    typedef struct packed {
        logic        pc_wr;
        logic        pc_sel;
        logic        ifid_wr;
        logic        ifid_clrn;
        logic        idex_clrn;
        logic        busy;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr;
    logic [4:0] d_rs, d_rt, e_rt;
    logic       d_uses_rt, e_memtoreg, e_regwr, e_branch, e_zero, e_jump;

    logic       pc_wr_a, pc_sel_a, ifid_wr_a, ifid_clrn_a, idex_clrn_a, busy_a;
    logic [15:0] stall_a, flush_a;
    logic       pc_wr_b, pc_sel_b, ifid_wr_b, ifid_clrn_b, idex_clrn_b, busy_b;
    logic [1:0] stall_b, flush_b;

    exp_t q0[$];
    exp_t q1[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   track = 1'b0;

    // Reference model: remaining flush cycles, plus event counts.
    int fl[2];
    int sc[2];
    int fc[2];
    int pen[2] = '{2, 4};
    int mx[2]  = '{65535, 3};

    always #5 clk = ~clk;

    hazard_ctrl #(.BR_PENALTY(2), .CNT_W(16)) dut_a (
        .CLK(clk), .Clr(clr), .D_Rs(d_rs), .D_Rt(d_rt), .D_UsesRt(d_uses_rt),
        .E_Rt(e_rt), .E_MemtoReg(e_memtoreg), .E_RegWr(e_regwr),
        .E_Branch(e_branch), .E_Zero(e_zero), .E_Jump(e_jump),
        .PC_Wr(pc_wr_a), .PC_Sel(pc_sel_a), .IF_ID_Wr(ifid_wr_a),
        .IF_ID_Clrn(ifid_clrn_a), .ID_EX_Clrn(idex_clrn_a), .Busy(busy_a),
        .Stall_Cnt(stall_a), .Flush_Cnt(flush_a)
    );

    hazard_ctrl #(.BR_PENALTY(4), .CNT_W(2)) dut_b (
        .CLK(clk), .Clr(clr), .D_Rs(d_rs), .D_Rt(d_rt), .D_UsesRt(d_uses_rt),
        .E_Rt(e_rt), .E_MemtoReg(e_memtoreg), .E_RegWr(e_regwr),
        .E_Branch(e_branch), .E_Zero(e_zero), .E_Jump(e_jump),
        .PC_Wr(pc_wr_b), .PC_Sel(pc_sel_b), .IF_ID_Wr(ifid_wr_b),
        .IF_ID_Clrn(ifid_clrn_b), .ID_EX_Clrn(idex_clrn_b), .Busy(busy_b),
        .Stall_Cnt(stall_b), .Flush_Cnt(flush_b)
    );

    task automatic cyc(input logic c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses, input logic [4:0] ert, input logic mtr,
                       input logic rw, input logic br, input logic z, input logic j);
        bit   redirect, loaduse;
        exp_t e;
        @(posedge clk);
        #1;
        clr = c; d_rs = rs; d_rt = rt; d_uses_rt = uses; e_rt = ert;
        e_memtoreg = mtr; e_regwr = rw; e_branch = br; e_zero = z; e_jump = j;
        redirect = (br && z) || j;
        loaduse  = mtr && rw && (ert != 0) && ((ert == rs) || (uses && ert == rt));
        for (int i = 0; i < 2; i++) begin
            e.busy  = (fl[i] > 0);
            e.stall = 32'(sc[i]);
            e.flush = 32'(fc[i]);
            if (c) begin
                {e.pc_wr, e.pc_sel, e.ifid_wr, e.ifid_clrn, e.idex_clrn} = 5'b00000;
                fl[i] = 0; sc[i] = 0; fc[i] = 0;
            end else if (fl[i] > 0) begin
                {e.pc_wr, e.pc_sel, e.ifid_wr, e.ifid_clrn, e.idex_clrn} = 5'b10100;
                fl[i] = fl[i] - 1;
            end else if (redirect) begin
                {e.pc_wr, e.pc_sel, e.ifid_wr, e.ifid_clrn, e.idex_clrn} = 5'b11100;
                if (fc[i] < mx[i]) fc[i] = fc[i] + 1;
                fl[i] = pen[i] - 1;
            end else if (loaduse) begin
                {e.pc_wr, e.pc_sel, e.ifid_wr, e.ifid_clrn, e.idex_clrn} = 5'b00010;
                if (sc[i] < mx[i]) sc[i] = sc[i] + 1;
            end else begin
                {e.pc_wr, e.pc_sel, e.ifid_wr, e.ifid_clrn, e.idex_clrn} = 5'b10111;
            end
            if (track) begin
                if (i == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    task automatic idle();
        cyc(1'b0, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input exp_t exp, input exp_t act);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got wr=%b sel=%b ifwr=%b ifclrn=%b exclrn=%b busy=%b stall=%0d flush=%0d ; expected wr=%b sel=%b ifwr=%b ifclrn=%b exclrn=%b busy=%b stall=%0d flush=%0d",
                     name, $time, act.pc_wr, act.pc_sel, act.ifid_wr, act.ifid_clrn,
                     act.idex_clrn, act.busy, act.stall, act.flush, exp.pc_wr,
                     exp.pc_sel, exp.ifid_wr, exp.ifid_clrn, exp.idex_clrn,
                     exp.busy, exp.stall, exp.flush);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) begin
            check("inst_pen2", q0.pop_front(),
                  {pc_wr_a, pc_sel_a, ifid_wr_a, ifid_clrn_a, idex_clrn_a, busy_a,
                   32'(stall_a), 32'(flush_a)});
        end
        if (q1.size() > 0) begin
            check("inst_pen4_cnt2", q1.pop_front(),
                  {pc_wr_b, pc_sel_b, ifid_wr_b, ifid_clrn_b, idex_clrn_b, busy_b,
                   32'(stall_b), 32'(flush_b)});
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; d_rs = 0; d_rt = 0; d_uses_rt = 0; e_rt = 0;
        e_memtoreg = 0; e_regwr = 0; e_branch = 0; e_zero = 0; e_jump = 0;
        // First reset cycle establishes DUT state; checking starts afterwards.
        cyc(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        track = 1'b1;
        cyc(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        // Load-use on rs, then bubble; then E_Rt=0 is never a hazard.
        cyc(1'b0, 5'd5, 5'd9, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        // rt match gated by D_UsesRt.
        cyc(1'b0, 5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        // Taken branch, then untaken branch.
        cyc(1'b0, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (4) idle();
        cyc(1'b0, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        // Jump with coincident load-use, then a jump during the flush window.
        cyc(1'b0, 5'd6, 5'd2, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) idle();
        // Reset in the second flush cycle of the long-penalty instance.
        cyc(1'b0, 5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        cyc(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        // Five stalls saturate the 2-bit counter at 3.
        repeat (5) begin
            cyc(1'b0, 5'd4, 5'd2, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            idle();
        end
        // Randomized traffic biased toward small register numbers.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 99) == 0),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom), 5'($urandom_range(0, 7)),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0), 1'($urandom),
                ($urandom_range(0, 15) == 0));
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d expected entries left, required 0/0",
                     q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
